// File: rtl/weight_loader_if.sv
// Stream-in / memory-write-port bundle for weight_loader.
// The slave modport is the loader's view: it consumes the stream and drives the write port.
interface weight_loader_if #(
  parameter int numNeurons   = 10,
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16
);
  logic                    s_valid;
  logic [dataWidth-1:0]    s_data;
  logic                    s_last;
  logic                    s_ready;
  logic [numNeurons-1:0]   wen;
  logic [addressWidth-1:0] wadd;
  logic [dataWidth-1:0]    win;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, wen, wadd, win
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, wen, wadd, win
  );
endinterface

// File: rtl/weight_loader.sv
// Streams a flat word stream into per-neuron weight memories, neuron-major order.
// Optional framing check against s_last: define WEIGHT_LOADER_LAST_CHECK_EN.
module weight_loader #(
  parameter int numNeurons   = 10,
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  weight_loader_if.slave bus,
  output logic           busy,
  output logic           done,
  output logic           error
);

  localparam int neuronWidth = (numNeurons > 1) ? $clog2(numNeurons) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH
  } state_t;

  state_t                  state_q, state_d;
  logic [addressWidth-1:0] wcnt_q, wcnt_d;
  logic [neuronWidth-1:0]  ncnt_q, ncnt_d;
  logic [numNeurons-1:0]   wen_q, wen_d;
  logic [addressWidth-1:0] wadd_q, wadd_d;
  logic [dataWidth-1:0]    win_q, win_d;

  logic handshake;
  logic wcntWrap;
  logic lastWord;

  assign handshake = bus.s_valid && (state_q == LOAD);
  assign wcntWrap  = (wcnt_q == addressWidth'(numWeight - 1));
  assign lastWord  = wcntWrap && (ncnt_q == neuronWidth'(numNeurons - 1));

`ifdef WEIGHT_LOADER_LAST_CHECK_EN
  logic error_q, error_d;
`else
  logic unusedLast;
  assign unusedLast = bus.s_last;
`endif

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ncnt_d  = ncnt_q;
    wen_d   = '0;
    wadd_d  = wadd_q;
    win_d   = win_q;
`ifdef WEIGHT_LOADER_LAST_CHECK_EN
    error_d = error_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          wcnt_d  = '0;
          ncnt_d  = '0;
`ifdef WEIGHT_LOADER_LAST_CHECK_EN
          error_d = 1'b0;
`endif
        end
      end

      LOAD: begin
        if (handshake) begin
          win_d  = bus.s_data;
          wadd_d = wcnt_q;
          wen_d  = numNeurons'(1) << ncnt_q;
          if (lastWord) begin
            state_d = FLUSH;
            wcnt_d  = '0;
            ncnt_d  = '0;
          end else if (wcntWrap) begin
            wcnt_d = '0;
            ncnt_d = ncnt_q + 1'b1;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
`ifdef WEIGHT_LOADER_LAST_CHECK_EN
          // An early s_last still writes its word but aborts the load without done.
          if (bus.s_last && !lastWord) begin
            error_d = 1'b1;
            state_d = IDLE;
          end
          if (!bus.s_last && lastWord) begin
            error_d = 1'b1;
          end
`endif
        end
      end

      FLUSH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      ncnt_q  <= '0;
      wen_q   <= '0;
      wadd_q  <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ncnt_q  <= ncnt_d;
      wen_q   <= wen_d;
      wadd_q  <= wadd_d;
      win_q   <= win_d;
    end
  end

`ifdef WEIGHT_LOADER_LAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign bus.s_ready = (state_q == LOAD);
  assign bus.wen     = wen_q;
  assign bus.wadd    = wadd_q;
  assign bus.win     = win_q;
  assign busy        = (state_q == LOAD);
  assign done        = (state_q == FLUSH);

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: randomized stream driver, scoreboard monitor
// and a behavioural model of the ten weight memories.
module tb_weight_loader;

  localparam int NN    = 10;
  localparam int NW    = 30;
  localparam int AW    = $clog2(NW);
  localparam int DW    = 16;
  localparam int TOTAL = NN * NW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;
  logic error;

  weight_loader_if #(.numNeurons(NN), .numWeight(NW), .addressWidth(AW), .dataWidth(DW)) bus ();

  weight_loader #(.numNeurons(NN), .numWeight(NW), .addressWidth(AW), .dataWidth(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bus  (bus),
    .busy (busy),
    .done (done),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            neuron;
    int            addr;
    logic [DW-1:0] data;
    bit            isLast;
  } exp_t;

  exp_t          expQ[$];
  exp_t          monEntry;
  int            checks    = 0;
  int            passes    = 0;
  int            doneCount = 0;
  bit            monOn     = 1'b0;
  bit            hsSeen    = 1'b0;
  logic [DW-1:0] mem     [NN][NW];
  logic [DW-1:0] expData [TOTAL];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual === required) passes++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
  endtask

  // Handshake tracker and memory model, both sampling pre-edge values.
  initial begin
    forever begin
      @(posedge clk);
      hsSeen = bus.s_valid && bus.s_ready;
      for (int n = 0; n < NN; n++) begin
        if (bus.wen[n] === 1'b1) mem[n][bus.wadd] = bus.win;
      end
    end
  end

  // Scoreboard monitor: every write must follow a handshake and match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (monOn) begin
        if (done === 1'b1) doneCount++;
        if ((bus.wen !== '0) || hsSeen) begin
          checkOutput("wenFollowsHandshake", 64'(bus.wen !== '0), 64'(hsSeen));
          if (bus.wen !== '0) begin
            if (expQ.size() == 0) begin
              checkOutput("unexpectedWrite", 64'(bus.wen), 64'(0));
            end else begin
              monEntry = expQ.pop_front();
              checkOutput("wen", 64'(bus.wen), 64'(1) << monEntry.neuron);
              checkOutput("wadd", 64'(bus.wadd), 64'(monEntry.addr));
              checkOutput("win", 64'(bus.win), 64'(monEntry.data));
              checkOutput("doneWithFinalWrite", 64'(done), 64'(monEntry.isLast));
            end
          end
        end else if (done !== 1'b0) begin
          checkOutput("spuriousDone", 64'(done), 64'(0));
        end
      end
    end
  end

  task automatic checkMemory();
    int bad = 0;
    for (int k = 0; k < TOTAL; k++) begin
      if (mem[k / NW][k % NW] !== expData[k]) bad++;
    end
    checkOutput("memContents", 64'(bad), 64'(0));
  endtask

  task automatic applyStimulus(input int gapMax, input bit randData, input int lastAt,
                               input int startAt, input int resetAt);
    int doneBefore;
    bit aborted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busyAfterStart", 64'(busy), 64'(1));
    checkOutput("readyAfterStart", 64'(bus.s_ready), 64'(1));
    checkOutput("errorClearedByStart", 64'(error), 64'(0));
    doneBefore = doneCount;
    for (int k = 0; k < TOTAL; k++) begin
      int gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        bus.s_valid = 1'b0;
        @(negedge clk);
      end
      expData[k]  = randData ? DW'($urandom) : DW'(k);
      bus.s_valid = 1'b1;
      bus.s_data  = expData[k];
      bus.s_last  = (lastAt >= 0) ? (k == lastAt) : (k == TOTAL - 1);
      start       = (k == startAt);
      if (bus.s_ready !== 1'b1) begin
        checkOutput("readyDuringLoad", 64'(bus.s_ready), 64'(1));
        aborted = 1'b1;
        break;
      end
      expQ.push_back('{neuron: k / NW, addr: k % NW, data: expData[k], isLast: (k == TOTAL - 1)});
      @(negedge clk);
      start = 1'b0;
      if (k == resetAt) begin
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        @(negedge clk);
        checkOutput("rstWen", 64'(bus.wen), 64'(0));
        checkOutput("rstWadd", 64'(bus.wadd), 64'(0));
        checkOutput("rstWin", 64'(bus.win), 64'(0));
        checkOutput("rstBusy", 64'(busy), 64'(0));
        checkOutput("rstReady", 64'(bus.s_ready), 64'(0));
        checkOutput("rstDone", 64'(done), 64'(0));
        checkOutput("rstError", 64'(error), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rstNoDone", 64'(doneCount - doneBefore), 64'(0));
        checkOutput("rstQueueEmpty", 64'(expQ.size()), 64'(0));
        return;
      end
`ifdef WEIGHT_LOADER_LAST_CHECK_EN
      if (k == lastAt) begin
        checkOutput("earlyLastError", 64'(error), 64'(1));
        checkOutput("earlyLastReady", 64'(bus.s_ready), 64'(0));
        aborted = 1'b1;
        break;
      end
`endif
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    start       = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("queueDrained", 64'(expQ.size()), 64'(0));
    checkOutput("busyAfterLoad", 64'(busy), 64'(0));
    checkOutput("readyAfterLoad", 64'(bus.s_ready), 64'(0));
    if (aborted) begin
      checkOutput("abortNoDone", 64'(doneCount - doneBefore), 64'(0));
      expQ.delete();
    end else begin
      checkOutput("doneOnce", 64'(doneCount - doneBefore), 64'(1));
      checkOutput("errorAfterLoad", 64'(error), 64'(0));
      checkMemory();
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetWen", 64'(bus.wen), 64'(0));
    checkOutput("resetReady", 64'(bus.s_ready), 64'(0));
    checkOutput("resetBusy", 64'(busy), 64'(0));
    checkOutput("resetDone", 64'(done), 64'(0));
    checkOutput("resetError", 64'(error), 64'(0));
    checkOutput("resetWadd", 64'(bus.wadd), 64'(0));
    checkOutput("resetWin", 64'(bus.win), 64'(0));
    rst_n = 1'b1;
    monOn = 1'b1;
    @(negedge clk);

    applyStimulus(0, 1'b0, -1, -1, -1);
    checkOutput("neuron1Addr1", 64'(mem[1][1]), 64'(31));
    checkOutput("neuron9Addr29", 64'(mem[9][29]), 64'(299));

    applyStimulus(5, 1'b1, -1, -1, -1);

    applyStimulus(0, 1'b1, -1, -1, 44);
    applyStimulus(0, 1'b1, -1, -1, -1);

    applyStimulus(2, 1'b1, -1, 100, -1);

    applyStimulus(1, 1'b1, 150, -1, -1);

    applyStimulus(1, 1'b1, -1, -1, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
